ifft_out_reorder: RTL and testbench

- Downstream of ifft; consumes its sample stream (oReal/oImag/oaddr/oen), which carries an index per sample in arbitrary order.
- Stores each frame by index into a ping-pong buffer, then replays it in natural order 0..N-1.
- Replay uses a valid/ready handshake so the consumer (DAC framer, file sink, next DSP stage) may stall without losing data.
- Absorbs one full frame of consumer latency.

---
 rtl/ifft_out_reorder_pkg.sv | 15 +
 rtl/fft_dpram.sv | 29 ++
 rtl/ifft_out_reorder.sv | 202 ++++++++++++++++++++
 tb/tb_ifft_out_reorder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifft_out_reorder_pkg.sv
// Shared constants and types for the IFFT output reorder buffer.
// Default frame geometry matches the upstream IFFT (N = 256, 16-bit I/Q).
package ifft_out_reorder_pkg;

  localparam int unsigned TOTAL_STAGE = 8;
  localparam int unsigned REAL_WIDTH  = 16;
  localparam int unsigned IMGN_WIDTH  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StStream
  } rd_state_e;

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle latency) read. Contents are not reset.
module fft_dpram #(
  parameter int unsigned AddrWidth = 9,
  parameter int unsigned Width     = 32
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ifft_out_reorder.sv
// Reorders IFFT output (arbitrary index order) into natural order through a
// ping-pong buffer and replays each frame over a valid/ready stream.
module ifft_out_reorder
  import ifft_out_reorder_pkg::*;
#(
  parameter int unsigned STAGE = TOTAL_STAGE,
  parameter int unsigned RW    = REAL_WIDTH,
  parameter int unsigned IW    = IMGN_WIDTH
) (
  input  logic             iclk,
  input  logic             rst_n,
  input  logic             ien,
  input  logic [STAGE-1:0] iaddr,
  input  logic [RW-1:0]    iReal,
  input  logic [IW-1:0]    iImag,
  output logic [RW-1:0]    oReal,
  output logic [IW-1:0]    oImag,
  output logic [STAGE-1:0] oaddr,
  output logic             ovalid,
  output logic             olast,
  input  logic             oready,
  output logic             ovf
);

  localparam int unsigned DW = RW + IW;
  localparam logic [STAGE-1:0] LastIdx = {STAGE{1'b1}};
  localparam logic [STAGE-1:0] OneIdx  = STAGE'(1);

  // Write side state
  logic [1:0]       full_q, full_d;
  logic             wbank_q, wbank_d;
  logic [STAGE-1:0] wcnt_q, wcnt_d;
  logic             ovf_q, ovf_d;

  // Read side state
  rd_state_e        st_q, st_d;
  logic             rbank_q, rbank_d;
  logic             rd_ok_q, rd_ok_d;
  logic [RW-1:0]    oreal_q, oreal_d;
  logic [IW-1:0]    oimag_q, oimag_d;
  logic [STAGE-1:0] oaddr_q, oaddr_d;
  logic             ovalid_q, ovalid_d;
  logic             olast_q, olast_d;

  logic             fire, free, wr_accept;
  logic             rd_bank;
  logic [STAGE-1:0] rd_idx;
  logic             pend_bank, nxt2_bank;
  logic [STAGE-1:0] pend_idx, nxt2_idx;
  logic [DW-1:0]    rdata;

  fft_dpram #(
    .AddrWidth(STAGE + 1),
    .Width    (DW)
  ) u_ram (
    .clk_i  (iclk),
    .we_i   (wr_accept),
    .waddr_i({wbank_q, iaddr}),
    .wdata_i({iReal, iImag}),
    .raddr_i({rd_bank, rd_idx}),
    .rdata_o(rdata)
  );

  // Write side: count-based frame completion; a bank freed this cycle may be written.
  always_comb begin
    fire      = ovalid_q && oready;
    free      = fire && olast_q;
    wr_accept = ien && (!full_q[wbank_q] || (free && (rbank_q == wbank_q)));
    full_d    = full_q;
    wbank_d   = wbank_q;
    wcnt_d    = wcnt_q;
    ovf_d     = ovf_q | (ien & ~wr_accept);
    if (free) begin
      full_d[rbank_q] = 1'b0;
    end
    if (wr_accept) begin
      if (wcnt_q == LastIdx) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
        wcnt_d          = '0;
      end else begin
        wcnt_d = wcnt_q + OneIdx;
      end
    end
  end

  // The RAM output always holds the sample after the one presented ("pend");
  // nxt2 is the one after that, fetched when the presented sample is accepted.
  always_comb begin
    pend_bank = rbank_q ^ (oaddr_q == LastIdx);
    pend_idx  = oaddr_q + OneIdx;
    nxt2_bank = pend_bank ^ (pend_idx == LastIdx);
    nxt2_idx  = pend_idx + OneIdx;
  end

  always_comb begin
    st_d     = st_q;
    rbank_d  = rbank_q;
    oreal_d  = oreal_q;
    oimag_d  = oimag_q;
    oaddr_d  = oaddr_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    rd_bank  = pend_bank;
    rd_idx   = pend_idx;

    unique case (st_q)
      StIdle: begin
        rd_bank = rbank_q;
        rd_idx  = '0;
        if (full_q[rbank_q]) begin
          st_d = StPrime;
        end
      end
      StPrime: begin
        {oreal_d, oimag_d} = rdata;
        oaddr_d  = '0;
        ovalid_d = 1'b1;
        olast_d  = 1'b0;
        rd_bank  = rbank_q;
        rd_idx   = OneIdx;
        st_d     = StStream;
      end
      StStream: begin
        if (fire) begin
          if (olast_q) begin
            rbank_d = ~rbank_q;
            if (rd_ok_q) begin
              // Prefetched index 0 of the other bank is valid: no bubble.
              {oreal_d, oimag_d} = rdata;
              oaddr_d = '0;
              olast_d = 1'b0;
              rd_bank = nxt2_bank;
              rd_idx  = nxt2_idx;
            end else begin
              ovalid_d = 1'b0;
              olast_d  = 1'b0;
              rd_bank  = ~rbank_q;
              rd_idx   = '0;
              st_d     = full_q[~rbank_q] ? StPrime : StIdle;
            end
          end else begin
            {oreal_d, oimag_d} = rdata;
            oaddr_d = pend_idx;
            olast_d = (pend_idx == LastIdx);
            rd_bank = nxt2_bank;
            rd_idx  = nxt2_idx;
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  // Data read at the next edge is trustworthy only if its bank is full now.
  always_comb begin
    rd_ok_d = full_q[rd_bank];
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= '0;
      wbank_q  <= 1'b0;
      wcnt_q   <= '0;
      ovf_q    <= 1'b0;
      st_q     <= StIdle;
      rbank_q  <= 1'b0;
      rd_ok_q  <= 1'b0;
      oreal_q  <= '0;
      oimag_q  <= '0;
      oaddr_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      full_q   <= full_d;
      wbank_q  <= wbank_d;
      wcnt_q   <= wcnt_d;
      ovf_q    <= ovf_d;
      st_q     <= st_d;
      rbank_q  <= rbank_d;
      rd_ok_q  <= rd_ok_d;
      oreal_q  <= oreal_d;
      oimag_q  <= oimag_d;
      oaddr_q  <= oaddr_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
    end
  end

  assign oReal  = oreal_q;
  assign oImag  = oimag_q;
  assign oaddr  = oaddr_q;
  assign ovalid = ovalid_q;
  assign olast  = olast_q;
  assign ovf    = ovf_q;

  a_olast_valid: assert property (@(posedge iclk) disable iff (!rst_n) olast_q |-> ovalid_q);

  a_stall_hold: assert property (@(posedge iclk) disable iff (!rst_n)
    (ovalid_q && !oready) |=> (ovalid_q && $stable({oaddr_q, oreal_q, oimag_q, olast_q})));

endmodule

// File: tb/tb_ifft_out_reorder.sv
// Scoreboard bench for ifft_out_reorder: frames are modelled by index as they
// are written and the expected natural-order stream is compared on acceptance.
module tb_ifft_out_reorder;

  localparam int N = 256;

  logic        iclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ien = 1'b0;
  logic [7:0]  iaddr = '0;
  logic [15:0] iReal = '0;
  logic [15:0] iImag = '0;
  logic [15:0] oReal;
  logic [15:0] oImag;
  logic [7:0]  oaddr;
  logic        ovalid;
  logic        olast;
  logic        oready = 1'b0;
  logic        ovf;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] r;
    logic [15:0] i;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 iclk = ~iclk;

  ifft_out_reorder #(
    .STAGE(8),
    .RW   (16),
    .IW   (16)
  ) dut (
    .iclk  (iclk),
    .rst_n (rst_n),
    .ien   (ien),
    .iaddr (iaddr),
    .iReal (iReal),
    .iImag (iImag),
    .oReal (oReal),
    .oImag (oImag),
    .oaddr (oaddr),
    .ovalid(ovalid),
    .olast (olast),
    .oready(oready),
    .ovf   (ovf)
  );

  function automatic logic [7:0] bitrev8(input logic [7:0] x);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = x[7-b];
    return r;
  endfunction

  // mode 0: natural index order, mode 1: bit-reversed order. Data = base + index.
  task automatic write_frame(input int mode, input int base, input bit push, input bit chk_ovf,
                             input int count);
    exp_t model [N];
    for (int k = 0; k < count; k++) begin
      logic [7:0]  addr;
      logic [15:0] v;
      logic        exp_ovf;
      addr = (mode == 1) ? bitrev8(8'(k)) : 8'(k);
      v    = 16'(base) + 16'(addr);
      @(posedge iclk);
      #1;
      if (chk_ovf && k < 2) begin
        exp_ovf = (k == 1);
        n_tests++;
        if (ovf !== exp_ovf) begin
          n_fail++;
          $display("FAIL ovf_edge: sample %0d ovf=%b required %b", k, ovf, exp_ovf);
        end
      end
      ien   = 1'b1;
      iaddr = addr;
      iReal = v;
      iImag = 16'(-v);
      model[addr] = '{a: addr, r: v, i: 16'(-v)};
    end
    if (push && count == N) begin
      for (int j = 0; j < N; j++) sb.push_back(model[j]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iclk);
      #1;
      ien = 1'b0;
    end
  endtask

  // Called at a sampling point (between edges). Consumes n_exp samples.
  task automatic drain(input int n_exp, input int unsigned pct, input int nobubble,
                       input int budget);
    int          acc = 0;
    int          cyc = 0;
    bit          prev_stall = 1'b0;
    logic [41:0] prev = '0;
    exp_t        e;
    while (acc < n_exp && cyc < budget) begin
      if (prev_stall) begin
        n_tests++;
        if ({ovalid, olast, oaddr, oReal, oImag} !== prev) begin
          n_fail++;
          $display("FAIL hold: got %h required %h", {ovalid, olast, oaddr, oReal, oImag}, prev);
        end
      end
      if (ovalid === 1'b1 && oready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_output: oaddr=%0d but nothing expected", oaddr);
        end else begin
          e = sb.pop_front();
          n_tests++;
          if ({oaddr, oReal, oImag} !== {e.a, e.r, e.i}) begin
            n_fail++;
            $display("FAIL sample: got addr=%0d re=%h im=%h required addr=%0d re=%h im=%h",
                     oaddr, oReal, oImag, e.a, e.r, e.i);
          end
          n_tests++;
          if (olast !== (e.a == 8'hff)) begin
            n_fail++;
            $display("FAIL olast: addr=%0d olast=%b required %b", oaddr, olast, (e.a == 8'hff));
          end
        end
        acc++;
      end else if (acc > 0 && acc < nobubble) begin
        n_tests++;
        if (ovalid !== 1'b1) begin
          n_fail++;
          $display("FAIL bubble: after %0d samples ovalid=%b required 1", acc, ovalid);
        end
      end
      prev_stall = (ovalid === 1'b1) && !oready;
      prev       = {ovalid, olast, oaddr, oReal, oImag};
      @(posedge iclk);
      #1;
      oready = ($urandom_range(99, 0) < pct);
      @(negedge iclk);
      cyc++;
    end
    n_tests++;
    if (acc != n_exp) begin
      n_fail++;
      $display("FAIL drain_timeout: accepted %0d required %0d", acc, n_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge iclk);
    n_tests++;
    if ({ovalid, olast, ovf, oaddr, oReal, oImag} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {ovalid, olast, ovf, oaddr, oReal, oImag});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge iclk);
    n_tests++;
    if ({ovalid, ovf} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: ovalid/ovf=%b required 00", {ovalid, ovf});
    end
  endtask

  task automatic test_natural();
    oready = 1'b1;
    write_frame(0, 0, 1'b1, 1'b0, N);
    idle(1);
    for (int c = 0; c < 3; c++) begin
      logic exp_v;
      exp_v = (c == 2);
      @(negedge iclk);
      n_tests++;
      if (ovalid !== exp_v) begin
        n_fail++;
        $display("FAIL latency: cycle %0d after last write ovalid=%b required %b", c, ovalid, exp_v);
      end
    end
    drain(N, 100, N, 400);
    n_tests++;
    if (ovalid !== 1'b0) begin
      n_fail++;
      $display("FAIL natural_end: ovalid=%b required 0", ovalid);
    end
  endtask

  task automatic test_bitrev();
    oready = 1'b1;
    fork
      begin
        write_frame(1, 0, 1'b1, 1'b0, N);
        idle(1);
      end
      begin
        @(negedge iclk);
        drain(N, 100, N, 700);
      end
    join
  endtask

  task automatic test_backpressure();
    oready = 1'b0;
    fork
      begin
        write_frame(0, 300, 1'b1, 1'b0, N);
        idle(1);
      end
      begin
        @(negedge iclk);
        drain(N, 50, 0, 3000);
      end
    join
  endtask

  task automatic test_back_to_back();
    oready = 1'b1;
    fork
      begin
        write_frame(0, 1000, 1'b1, 1'b0, N);
        write_frame(0, 2000, 1'b1, 1'b0, N);
        idle(1);
        write_frame(0, 3000, 1'b1, 1'b0, N);
        idle(1);
      end
      begin
        @(negedge iclk);
        drain(3 * N, 100, 2 * N, 1400);
      end
    join
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ovf: ovf=%b required 0", ovf);
    end
  endtask

  task automatic test_overflow();
    oready = 1'b0;
    write_frame(0, 4000, 1'b1, 1'b0, N);
    write_frame(0, 5000, 1'b1, 1'b0, N);
    write_frame(0, 6000, 1'b0, 1'b1, N);
    idle(1);
    @(negedge iclk);
    n_tests++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b required 1", ovf);
    end
    oready = 1'b1;
    drain(2 * N, 100, 0, 1500);
    repeat (3) @(negedge iclk);
    n_tests++;
    if ({ovalid, ovf} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovf_after: ovalid/ovf=%b required 01", {ovalid, ovf});
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int cyc = 0;
    oready = 1'b1;
    write_frame(0, 7000, 1'b1, 1'b0, N);
    write_frame(0, 8000, 1'b0, 1'b0, 60);
    idle(1);
    while (!found && cyc < 400) begin
      @(negedge iclk);
      cyc++;
      if (ovalid === 1'b1 && oaddr == 8'd100) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_idx100: never saw oaddr=100 (ovalid=%b oaddr=%0d)", ovalid, oaddr);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ovalid, olast, ovf, oaddr} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: ovalid/olast/ovf/oaddr=%h required 0", {ovalid, olast, ovf, oaddr});
    end
    sb.delete();
    repeat (3) @(negedge iclk);
    rst_n = 1'b1;
    repeat (5) @(negedge iclk);
    n_tests++;
    if (ovalid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: ovalid=%b required 0", ovalid);
    end
    fork
      begin
        write_frame(0, 9000, 1'b1, 1'b0, N);
        idle(1);
      end
      begin
        @(negedge iclk);
        drain(N, 100, N, 700);
      end
    join
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_ovf: ovf=%b required 0", ovf);
    end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
